// File: rtl/ipv4_encap.sv
// ipv4_encap: prepends a 20-byte IPv4 header (no options, DF set) to a 64-bit payload stream.
// The header is 20 bytes, so payload is shifted by 4 bytes through a 32-bit residue register.
module ipv4_encap #(
  parameter int         inwidth = 64,
  parameter logic [7:0] TTL     = 8'd64,
  parameter logic [7:0] TOS     = 8'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [inwidth-1:0] din,
  input  logic [7:0]         tkeep,
  input  logic               tvalid,
  input  logic               tlast,
  output logic               tready,
  input  logic [31:0]        src_ip,
  input  logic [31:0]        dst_ip,
  input  logic [7:0]         protocol,
  input  logic [15:0]        payload_len,
  output logic [inwidth-1:0] out,
  output logic [7:0]         out_keep,
  output logic               outvalid,
  input  logic               out_ready,
  output logic               tlast_out,
  output logic               parsing
);
  // state | meaning
  // IDLE  | waiting for a packet; sideband captured on tvalid
  // CSUM  | header checksum registered
  // HDR0  | emit header bytes 0-7
  // HDR1  | emit header bytes 8-15
  // HDR2  | emit dst_ip + first 4 payload bytes
  // BODY  | emit residue + next 4 payload bytes
  // TAIL  | emit leftover residue bytes
  typedef enum logic [2:0] {IDLE, CSUM, HDR0, HDR1, HDR2, BODY, TAIL} state_t;

  state_t      state_q, state_d;
  logic [31:0] src_q, src_d, dst_q, dst_d, residue_q, residue_d;
  logic [7:0]  proto_q, proto_d, tail_keep_q, tail_keep_d, keep_q, keep_d;
  logic [15:0] len_q, len_d, csum_q, csum_d, id_q, id_d;
  logic [63:0] out_q, out_d;
  logic        ovalid_q, ovalid_d, tlast_q, tlast_d;
  logic        adv;
  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  assign adv       = !ovalid_q || out_ready;
  assign tready    = ((state_q == HDR2) || (state_q == BODY)) && adv;
  assign parsing   = (state_q != IDLE);
  assign out       = out_q;
  assign out_keep  = keep_q;
  assign outvalid  = ovalid_q;
  assign tlast_out = tlast_q;

  assign sum = 20'({8'h45, TOS}) + 20'(len_q) + 20'(id_q) + 20'h04000
             + 20'({TTL, proto_q}) + 20'(src_q[31:16]) + 20'(src_q[15:0])
             + 20'(dst_q[31:16]) + 20'(dst_q[15:0]);
  assign fold1 = 17'(sum[15:0]) + 17'(sum[19:16]);
  assign fold2 = fold1[15:0] + 16'(fold1[16]);

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    proto_d     = proto_q;
    len_d       = len_q;
    csum_d      = csum_q;
    residue_d   = residue_q;
    tail_keep_d = tail_keep_q;
    out_d       = out_q;
    keep_d      = keep_q;
    tlast_d     = tlast_q;
    ovalid_d    = ovalid_q && !out_ready;
    id_d        = id_q + 16'(ovalid_q && out_ready && tlast_q);
    case (state_q)
      IDLE: begin
        // wait for the previous tlast handshake so the id counter has already advanced
        if (tvalid && !ovalid_q) begin
          src_d   = src_ip;
          dst_d   = dst_ip;
          proto_d = protocol;
          len_d   = payload_len + 16'd20;
          state_d = CSUM;
        end
      end
      CSUM: begin
        csum_d  = ~fold2;
        state_d = HDR0;
      end
      HDR0: if (adv) begin
        out_d    = {8'h45, TOS, len_q, id_q, 16'h4000};
        keep_d   = 8'hFF;
        tlast_d  = 1'b0;
        ovalid_d = 1'b1;
        state_d  = HDR1;
      end
      HDR1: if (adv) begin
        out_d    = {TTL, proto_q, csum_q, src_q};
        keep_d   = 8'hFF;
        tlast_d  = 1'b0;
        ovalid_d = 1'b1;
        state_d  = HDR2;
      end
      HDR2, BODY: if (tvalid && adv) begin
        out_d     = {((state_q == HDR2) ? dst_q : residue_q), din[63:32]};
        residue_d = din[31:0];
        ovalid_d  = 1'b1;
        keep_d    = 8'hFF;
        tlast_d   = 1'b0;
        state_d   = BODY;
        if (tlast) begin
          // tkeep is contiguous from the MSB, so tkeep[3] set means more than 4 bytes
          if (tkeep[3]) begin
            tail_keep_d = {tkeep[3:0], 4'h0};
            state_d     = TAIL;
          end else begin
            keep_d  = {4'hF, tkeep[7:4]};
            tlast_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      TAIL: if (adv) begin
        out_d    = {residue_q, 32'h0};
        keep_d   = tail_keep_q;
        tlast_d  = 1'b1;
        ovalid_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      proto_q     <= '0;
      len_q       <= '0;
      csum_q      <= '0;
      residue_q   <= '0;
      tail_keep_q <= '0;
      out_q       <= '0;
      keep_q      <= '0;
      tlast_q     <= 1'b0;
      ovalid_q    <= 1'b0;
      id_q        <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      proto_q     <= proto_d;
      len_q       <= len_d;
      csum_q      <= csum_d;
      residue_q   <= residue_d;
      tail_keep_q <= tail_keep_d;
      out_q       <= out_d;
      keep_q      <= keep_d;
      tlast_q     <= tlast_d;
      ovalid_q    <= ovalid_d;
      id_q        <= id_d;
    end
  end
endmodule

// File: tb/tb_ipv4_encap.sv
// Directed bench for ipv4_encap: compares the emitted byte stream against a header/payload byte model.
module tb_ipv4_encap;
  logic        clk, rst_n;
  logic [63:0] din, out;
  logic [7:0]  tkeep, protocol, out_keep;
  logic        tvalid, tlast, tready, outvalid, out_ready, tlast_out, parsing;
  logic [31:0] src_ip, dst_ip;
  logic [15:0] payload_len;

  ipv4_encap dut (
    .clk(clk), .rst_n(rst_n), .din(din), .tkeep(tkeep), .tvalid(tvalid), .tlast(tlast),
    .tready(tready), .src_ip(src_ip), .dst_ip(dst_ip), .protocol(protocol),
    .payload_len(payload_len), .out(out), .out_keep(out_keep), .outvalid(outvalid),
    .out_ready(out_ready), .tlast_out(tlast_out), .parsing(parsing)
  );

  int total = 0;
  int bad = 0;
  logic [63:0] cap_w[$];
  logic [7:0]  cap_k[$];
  logic        cap_l[$];
  logic [7:0]  exp_b[$];
  logic [15:0] exp_id, exp_cs;
  bit          drv_timeout, col_timeout, stall_mode;
  int          viol;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = stall_mode ? ~out_ready : 1'b1;
    end
  end

  function automatic logic [7:0] pat(input int seed, input int i);
    int v;
    v = seed + i * 37;
    return v[7:0];
  endfunction

  function automatic logic [15:0] ref_csum(input logic [7:0] h[20]);
    logic [16:0] acc;
    acc = '0;
    for (int i = 0; i < 20; i += 2) begin
      acc = 17'(acc[15:0]) + 17'({h[i], h[i+1]});
      acc = 17'(acc[15:0]) + 17'(acc[16]);
    end
    return ~acc[15:0];
  endfunction

  task automatic build_exp(input logic [31:0] s, input logic [31:0] d, input logic [7:0] p,
                           input int n, input logic [15:0] id, input int seed);
    logic [7:0]  h[20];
    logic [15:0] tl;
    tl = 16'(n + 20);
    h[0] = 8'h45; h[1] = 8'h00; h[2] = tl[15:8]; h[3] = tl[7:0];
    h[4] = id[15:8]; h[5] = id[7:0]; h[6] = 8'h40; h[7] = 8'h00;
    h[8] = 8'd64; h[9] = p; h[10] = 8'h00; h[11] = 8'h00;
    h[12] = s[31:24]; h[13] = s[23:16]; h[14] = s[15:8]; h[15] = s[7:0];
    h[16] = d[31:24]; h[17] = d[23:16]; h[18] = d[15:8]; h[19] = d[7:0];
    exp_cs = ref_csum(h);
    h[10] = exp_cs[15:8];
    h[11] = exp_cs[7:0];
    exp_b.delete();
    for (int i = 0; i < 20; i++) exp_b.push_back(h[i]);
    for (int i = 0; i < n; i++) exp_b.push_back(pat(seed, i));
  endtask

  function automatic int stream_errs(input int w0);
    int t, nw, e;
    t = exp_b.size();
    nw = (t + 7) / 8;
    e = 0;
    if (cap_w.size() < w0 + nw) return 999;
    for (int j = 0; j < nw; j++) begin
      for (int b = 0; b < 8; b++) begin
        int   idx;
        logic kb;
        idx = j * 8 + b;
        kb = (idx < t);
        if (cap_k[w0+j][7-b] !== kb) e++;
        else if (kb && (cap_w[w0+j][63-8*b -: 8] !== exp_b[idx])) e++;
      end
      if (cap_l[w0+j] !== (j == nw - 1)) e++;
    end
    return e;
  endfunction

  task automatic send_pkt(input logic [31:0] s, input logic [31:0] d, input logic [7:0] p,
                          input int n, input int seed, input int gap);
    int nw;
    nw = (n + 7) / 8;
    for (int i = 0; i < nw; i++) begin
      logic [63:0] w;
      logic [7:0]  kp;
      int          cnt;
      w = '0;
      kp = '0;
      for (int b = 0; b < 8; b++)
        if (i * 8 + b < n) begin
          w[63-8*b -: 8] = pat(seed, i * 8 + b);
          kp[7-b] = 1'b1;
        end
      @(negedge clk);
      src_ip = s; dst_ip = d; protocol = p; payload_len = 16'(n);
      din = w; tkeep = kp; tlast = (i == nw - 1); tvalid = 1'b1;
      #2;
      cnt = 0;
      while (!tready && cnt < 1000) begin
        @(negedge clk);
        #2;
        cnt++;
      end
      if (cnt >= 1000) drv_timeout = 1'b1;
      @(posedge clk);
      if (gap > 0 && i < nw - 1) begin
        @(negedge clk);
        tvalid = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    tvalid = 1'b0;
    tlast = 1'b0;
  endtask

  task automatic collect();
    int          cyc;
    bit          done, pend;
    logic [63:0] pw;
    logic [7:0]  pk;
    logic        pl;
    cyc = 0; done = 0; pend = 0; pw = '0; pk = '0; pl = 1'b0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      #3;
      if (pend && (out !== pw || out_keep !== pk || tlast_out !== pl)) viol++;
      if (outvalid && !out_ready && tready) viol++;
      if (outvalid && out_ready) begin
        cap_w.push_back(out);
        cap_k.push_back(out_keep);
        cap_l.push_back(tlast_out);
        if (tlast_out) done = 1;
        pend = 0;
      end else if (outvalid) begin
        pend = 1; pw = out; pk = out_keep; pl = tlast_out;
      end else pend = 0;
      cyc++;
    end
    if (!done) col_timeout = 1'b1;
  endtask

  task automatic clear_caps();
    cap_w.delete(); cap_k.delete(); cap_l.delete();
    drv_timeout = 0; col_timeout = 0; viol = 0;
  endtask

  task automatic run_pkt(input logic [31:0] s, input logic [31:0] d, input logic [7:0] p,
                         input int n, input int seed, input int gap);
    clear_caps();
    fork
      send_pkt(s, d, p, n, seed, gap);
      collect();
    join
    build_exp(s, d, p, n, exp_id, seed);
    exp_id++;
  endtask

  task automatic test_reset();
    rst_n = 0; tvalid = 0; tlast = 0; din = '0; tkeep = '0;
    src_ip = '0; dst_ip = '0; protocol = '0; payload_len = '0;
    stall_mode = 0; exp_id = 16'h0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (outvalid !== 1'b0) begin bad++; $display("FAIL reset_outvalid got=%0b want=0", outvalid); end
    total++; if (tready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%0b want=0", tready); end
    total++; if (parsing !== 1'b0) begin bad++; $display("FAIL reset_parsing got=%0b want=0", parsing); end
    total++; if (tlast_out !== 1'b0) begin bad++; $display("FAIL reset_tlast_out got=%0b want=0", tlast_out); end
    total++; if (out !== 64'h0) begin bad++; $display("FAIL reset_out got=%h want=0", out); end
    total++; if (out_keep !== 8'h0) begin bad++; $display("FAIL reset_keep got=%h want=0", out_keep); end
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int e;
    run_pkt(32'hC0A80001, 32'hC0A800C7, 8'h11, 16, 1, 0);
    total++; if (drv_timeout || col_timeout) begin bad++; $display("FAIL basic_timeout got=%0b%0b want=00", drv_timeout, col_timeout); end
    total++; if (cap_w.size() !== 5) begin bad++; $display("FAIL basic_words got=%0d want=5", cap_w.size()); end
    total++; if (cap_w[0] !== 64'h4500002400004000) begin bad++; $display("FAIL basic_hdr0 got=%h want=4500002400004000", cap_w[0]); end
    total++; if (cap_w[1] !== 64'h4011B8B0C0A80001) begin bad++; $display("FAIL basic_hdr1 got=%h want=4011b8b0c0a80001", cap_w[1]); end
    total++; if (cap_k[4] !== 8'hF0 || cap_l[4] !== 1'b1) begin bad++; $display("FAIL basic_last got=%h/%0b want=f0/1", cap_k[4], cap_l[4]); end
    e = stream_errs(0);
    total++; if (e !== 0) begin bad++; $display("FAIL basic_stream got=%0d errs want=0", e); end
  endtask

  task automatic test_tail();
    int e;
    run_pkt(32'h0A010203, 32'h0A040506, 8'h06, 46, 9, 0);
    total++; if (cap_w.size() !== 9) begin bad++; $display("FAIL tail_words got=%0d want=9", cap_w.size()); end
    total++; if (cap_k[7] !== 8'hFF || cap_l[7] !== 1'b0) begin bad++; $display("FAIL tail_body got=%h/%0b want=ff/0", cap_k[7], cap_l[7]); end
    total++; if (cap_k[8] !== 8'hC0 || cap_l[8] !== 1'b1) begin bad++; $display("FAIL tail_last got=%h/%0b want=c0/1", cap_k[8], cap_l[8]); end
    e = stream_errs(0);
    total++; if (e !== 0) begin bad++; $display("FAIL tail_stream got=%0d errs want=0", e); end
  endtask

  task automatic test_single();
    int e;
    run_pkt(32'h01020304, 32'h05060708, 8'h01, 3, 77, 0);
    total++; if (cap_w.size() !== 3) begin bad++; $display("FAIL single_words got=%0d want=3", cap_w.size()); end
    total++; if (cap_k[2] !== 8'hFE || cap_l[2] !== 1'b1) begin bad++; $display("FAIL single_last got=%h/%0b want=fe/1", cap_k[2], cap_l[2]); end
    e = stream_errs(0);
    total++; if (e !== 0) begin bad++; $display("FAIL single_stream got=%0d errs want=0", e); end
  endtask

  task automatic test_stall();
    int e;
    stall_mode = 1;
    run_pkt(32'hAC100001, 32'hAC100002, 8'h11, 64, 200, 0);
    stall_mode = 0;
    @(negedge clk);
    total++; if (cap_w.size() !== 11) begin bad++; $display("FAIL stall_words got=%0d want=11", cap_w.size()); end
    total++; if (viol !== 0) begin bad++; $display("FAIL stall_hold got=%0d violations want=0", viol); end
    e = stream_errs(0);
    total++; if (e !== 0) begin bad++; $display("FAIL stall_stream got=%0d errs want=0", e); end
  endtask

  task automatic test_bubbles();
    int e;
    run_pkt(32'h11223344, 32'h55667788, 8'h2F, 20, 31, 3);
    total++; if (drv_timeout || col_timeout) begin bad++; $display("FAIL bubble_timeout got=%0b%0b want=00", drv_timeout, col_timeout); end
    e = stream_errs(0);
    total++; if (e !== 0) begin bad++; $display("FAIL bubble_stream got=%0d errs want=0", e); end
  endtask

  task automatic test_back_to_back();
    int e;
    logic [15:0] id_a;
    id_a = exp_id;
    clear_caps();
    fork
      begin
        send_pkt(32'hC0000201, 32'hC0000202, 8'h11, 8, 5, 0);
        send_pkt(32'hC0000203, 32'hC0000204, 8'h06, 8, 6, 0);
      end
      begin
        collect();
        collect();
      end
    join
    total++; if (cap_w.size() !== 8) begin bad++; $display("FAIL b2b_words got=%0d want=8", cap_w.size()); end
    build_exp(32'hC0000201, 32'hC0000202, 8'h11, 8, id_a, 5);
    e = stream_errs(0);
    total++; if (e !== 0) begin bad++; $display("FAIL b2b_first got=%0d errs want=0", e); end
    build_exp(32'hC0000203, 32'hC0000204, 8'h06, 8, id_a + 16'd1, 6);
    e = stream_errs(4);
    total++; if (e !== 0) begin bad++; $display("FAIL b2b_second got=%0d errs want=0", e); end
    exp_id = id_a + 16'd2;
  endtask

  task automatic test_reset_mid();
    int e;
    @(negedge clk);
    src_ip = 32'hDEAD0001; dst_ip = 32'hDEAD0002; protocol = 8'h11; payload_len = 16'd64;
    din = 64'h0123456789ABCDEF; tkeep = 8'hFF; tlast = 1'b0; tvalid = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    total++; if (parsing !== 1'b1 || outvalid !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%0b/%0b want=1/1", parsing, outvalid); end
    #1 rst_n = 0;
    #1;
    total++; if (outvalid !== 1'b0) begin bad++; $display("FAIL midrst_outvalid got=%0b want=0", outvalid); end
    total++; if (parsing !== 1'b0 || tready !== 1'b0) begin bad++; $display("FAIL midrst_ctrl got=%0b/%0b want=0/0", parsing, tready); end
    @(negedge clk);
    tvalid = 1'b0;
    rst_n = 1;
    exp_id = 16'h0;
    @(negedge clk);
    run_pkt(32'hC0A80A01, 32'hC0A80A02, 8'h11, 20, 12, 0);
    total++; if (cap_w[0][31:16] !== 16'h0000) begin bad++; $display("FAIL midrst_id got=%h want=0000", cap_w[0][31:16]); end
    total++; if (cap_w[1][47:32] !== exp_cs) begin bad++; $display("FAIL midrst_csum got=%h want=%h", cap_w[1][47:32], exp_cs); end
    e = stream_errs(0);
    total++; if (e !== 0) begin bad++; $display("FAIL midrst_stream got=%0d errs want=0", e); end
  endtask

  task automatic test_id_wrap();
    int e;
    logic [15:0] want_id;
    @(negedge clk);
    dut.id_q = 16'hFFFE;
    exp_id = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      want_id = exp_id;
      run_pkt(32'h0A000001 + 32'(i), 32'h0A0000FE, 8'h06, 5 + i, 50 + i, 0);
      total++; if (cap_w[0][31:16] !== want_id) begin bad++; $display("FAIL wrap_id%0d got=%h want=%h", i, cap_w[0][31:16], want_id); end
      total++; if (cap_w[1][47:32] !== exp_cs) begin bad++; $display("FAIL wrap_csum%0d got=%h want=%h", i, cap_w[1][47:32], exp_cs); end
      e = stream_errs(0);
      total++; if (e !== 0) begin bad++; $display("FAIL wrap_stream%0d got=%0d errs want=0", i, e); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tail();
    test_single();
    test_stall();
    test_bubbles();
    test_back_to_back();
    test_reset_mid();
    test_id_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
